// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares the register-file write port between EX, MUL, DIV and FPU.
// EX has priority unless a long-latency unit has been blocked for MAX_WAIT cycles.
module wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int MAX_WAIT = 4,
  parameter int WAIT_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in_ex,
  input  logic              valid_in_mul,
  input  logic              valid_in_div,
  input  logic              valid_in_fpu,
  output logic              ready_out_ex,
  output logic              ready_out_mul,
  output logic              ready_out_div,
  output logic              ready_out_fpu,
  input  logic              rd_wena_ex,
  input  logic              rd_wena_mul,
  input  logic              rd_wena_div,
  input  logic              rd_wena_fpu,
  input  logic [ADDR_W-1:0] rd_addr_ex,
  input  logic [ADDR_W-1:0] rd_addr_mul,
  input  logic [ADDR_W-1:0] rd_addr_div,
  input  logic [ADDR_W-1:0] rd_addr_fpu,
  input  logic [DATA_W-1:0] rd_data_ex,
  input  logic [DATA_W-1:0] rd_data_mul,
  input  logic [DATA_W-1:0] rd_data_div,
  input  logic [DATA_W-1:0] rd_data_fpu,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              rd_wena_to_WB,
  output logic [ADDR_W-1:0] rd_addr_to_WB,
  output logic [DATA_W-1:0] rd_data_to_WB,
  output logic [1:0]        src_WB
);

  localparam logic [1:0] SRC_EX  = 2'd0;
  localparam logic [1:0] SRC_MUL = 2'd1;
  localparam logic [1:0] SRC_DIV = 2'd2;
  localparam logic [1:0] SRC_FPU = 2'd3;

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  logic              load;
  logic              en;
  logic [2:0]        lv;
  logic [2:0]        starved;
  logic [1:0]        ptr;
  logic [WAIT_W-1:0] wait_q [3];
  logic              gnt_ex;
  logic [2:0]        gnt_lu;
  logic [2:0]        rdy_lu;
  logic              any_gnt;
  logic              wena_q;
  logic              n_wena;
  logic [ADDR_W-1:0] n_addr;
  logic [DATA_W-1:0] n_data;
  logic [1:0]        n_src;

  // bit 0 = MUL, bit 1 = DIV, bit 2 = FPU; ptr holds the SRC code
  function automatic logic [2:0] rr_pick(
    input logic [2:0] req,
    input logic [1:0] p
  );
    logic [2:0] g;
    g = 3'b000;
    case (p)
      SRC_DIV: begin
        if (req[1])      g = 3'b010;
        else if (req[2]) g = 3'b100;
        else if (req[0]) g = 3'b001;
      end
      SRC_FPU: begin
        if (req[2])      g = 3'b100;
        else if (req[0]) g = 3'b001;
        else if (req[1]) g = 3'b010;
      end
      default: begin
        if (req[0])      g = 3'b001;
        else if (req[1]) g = 3'b010;
        else if (req[2]) g = 3'b100;
      end
    endcase
    return g;
  endfunction

  assign load = !valid_out || ready_in;
  assign en   = load && reset;
  assign lv   = {valid_in_fpu, valid_in_div, valid_in_mul};

  for (genvar i = 0; i < 3; i++) begin : g_starve
    assign starved[i] = lv[i] && (wait_q[i] >= WAIT_MAX);
  end

  always_comb begin
    gnt_ex = 1'b0;
    gnt_lu = 3'b000;
    if (|starved)         gnt_lu = rr_pick(starved, ptr);
    else if (valid_in_ex) gnt_ex = 1'b1;
    else                  gnt_lu = rr_pick(lv, ptr);
  end

  assign any_gnt       = gnt_ex || (|gnt_lu);
  assign rdy_lu        = gnt_lu & {3{en}};
  assign ready_out_ex  = gnt_ex && en;
  assign ready_out_mul = rdy_lu[0];
  assign ready_out_div = rdy_lu[1];
  assign ready_out_fpu = rdy_lu[2];

  always_comb begin
    n_wena = rd_wena_ex;
    n_addr = rd_addr_ex;
    n_data = rd_data_ex;
    n_src  = SRC_EX;
    unique case (1'b1)
      gnt_lu[0]: begin
        n_wena = rd_wena_mul;
        n_addr = rd_addr_mul;
        n_data = rd_data_mul;
        n_src  = SRC_MUL;
      end
      gnt_lu[1]: begin
        n_wena = rd_wena_div;
        n_addr = rd_addr_div;
        n_data = rd_data_div;
        n_src  = SRC_DIV;
      end
      gnt_lu[2]: begin
        n_wena = rd_wena_fpu;
        n_addr = rd_addr_fpu;
        n_data = rd_data_fpu;
        n_src  = SRC_FPU;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out     <= 1'b0;
      wena_q        <= 1'b0;
      rd_addr_to_WB <= '0;
      rd_data_to_WB <= '0;
      src_WB        <= SRC_EX;
    end else if (load) begin
      valid_out <= any_gnt;
      if (any_gnt) begin
        wena_q        <= n_wena;
        rd_addr_to_WB <= n_addr;
        rd_data_to_WB <= n_data;
        src_WB        <= n_src;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= SRC_MUL;
    end else if (|rdy_lu) begin
      unique case (1'b1)
        rdy_lu[0]: ptr <= SRC_DIV;
        rdy_lu[1]: ptr <= SRC_FPU;
        rdy_lu[2]: ptr <= SRC_MUL;
        default:   ptr <= ptr;
      endcase
    end
  end

  // counters keep running under backpressure so stalls count toward starvation
  for (genvar i = 0; i < 3; i++) begin : g_wait
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wait_q[i] <= '0;
      end else if (!lv[i] || rdy_lu[i]) begin
        wait_q[i] <= '0;
      end else if (wait_q[i] < WAIT_MAX) begin
        wait_q[i] <= wait_q[i] + 1'b1;
      end
    end
  end

  assign rd_wena_to_WB = valid_out && wena_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, round-robin, starvation,
// backpressure, wena=0 passthrough and mid-stream reset.
module tb_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        valid_in_ex, valid_in_mul, valid_in_div, valid_in_fpu;
  logic        ready_out_ex, ready_out_mul, ready_out_div, ready_out_fpu;
  logic        rd_wena_ex, rd_wena_mul, rd_wena_div, rd_wena_fpu;
  logic [5:0]  rd_addr_ex, rd_addr_mul, rd_addr_div, rd_addr_fpu;
  logic [31:0] rd_data_ex, rd_data_mul, rd_data_div, rd_data_fpu;
  logic        valid_out;
  logic        ready_in;
  logic        rd_wena_to_WB;
  logic [5:0]  rd_addr_to_WB;
  logic [31:0] rd_data_to_WB;
  logic [1:0]  src_WB;
  logic [3:0]  rdy;

  int total = 0;
  int bad   = 0;

  wb_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in_ex   (valid_in_ex),
    .valid_in_mul  (valid_in_mul),
    .valid_in_div  (valid_in_div),
    .valid_in_fpu  (valid_in_fpu),
    .ready_out_ex  (ready_out_ex),
    .ready_out_mul (ready_out_mul),
    .ready_out_div (ready_out_div),
    .ready_out_fpu (ready_out_fpu),
    .rd_wena_ex    (rd_wena_ex),
    .rd_wena_mul   (rd_wena_mul),
    .rd_wena_div   (rd_wena_div),
    .rd_wena_fpu   (rd_wena_fpu),
    .rd_addr_ex    (rd_addr_ex),
    .rd_addr_mul   (rd_addr_mul),
    .rd_addr_div   (rd_addr_div),
    .rd_addr_fpu   (rd_addr_fpu),
    .rd_data_ex    (rd_data_ex),
    .rd_data_mul   (rd_data_mul),
    .rd_data_div   (rd_data_div),
    .rd_data_fpu   (rd_data_fpu),
    .valid_out     (valid_out),
    .ready_in      (ready_in),
    .rd_wena_to_WB (rd_wena_to_WB),
    .rd_addr_to_WB (rd_addr_to_WB),
    .rd_data_to_WB (rd_data_to_WB),
    .src_WB        (src_WB)
  );

  assign rdy = {ready_out_fpu, ready_out_div, ready_out_mul, ready_out_ex};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [3:0] er);
    #1;
    chk(tag, 64'(rdy), 64'(er));
    @(posedge clk);
    #1;
  endtask

  task automatic outc(input string tag, input logic v, input logic we,
                      input logic [5:0] a, input logic [1:0] s);
    chk({tag, ".v"}, 64'(valid_out), 64'(v));
    chk({tag, ".we"}, 64'(rd_wena_to_WB), 64'(we));
    chk({tag, ".a"}, 64'(rd_addr_to_WB), 64'(a));
    chk({tag, ".s"}, 64'(src_WB), 64'(s));
  endtask

  task automatic idle_all();
    valid_in_ex  = 0;
    valid_in_mul = 0;
    valid_in_div = 0;
    valid_in_fpu = 0;
  endtask

  initial begin
    reset = 0;
    ready_in = 1;
    valid_in_ex = 1; valid_in_mul = 1; valid_in_div = 1; valid_in_fpu = 1;
    rd_wena_ex = 1; rd_wena_mul = 1; rd_wena_div = 1; rd_wena_fpu = 1;
    rd_addr_ex = 6'd1; rd_addr_mul = 6'd2;
    rd_addr_div = 6'd3; rd_addr_fpu = 6'd4;
    rd_data_ex = 32'h1; rd_data_mul = 32'h2;
    rd_data_div = 32'h3; rd_data_fpu = 32'h4;

    // reset held with every requester valid
    #3;
    chk("rst.rdy", 64'(rdy), 64'h0);
    chk("rst.v", 64'(valid_out), 64'h0);
    @(posedge clk); #1;
    chk("rst.v2", 64'(valid_out), 64'h0);
    chk("rst.src", 64'(src_WB), 64'h0);
    @(negedge clk);
    reset = 1;
    cyc("rel.g", 4'b0001);
    outc("rel.o", 1, 1, 6'd1, 2'd0);
    idle_all();
    cyc("rel.idle", 4'b0000);
    chk("rel.v0", 64'(valid_out), 64'h0);

    // round-robin among MUL/DIV/FPU
    rd_addr_mul = 6'd5; rd_addr_div = 6'd6; rd_addr_fpu = 6'd7;
    valid_in_mul = 1; valid_in_div = 1; valid_in_fpu = 1;
    cyc("rr.g0", 4'b0010);
    outc("rr.o0", 1, 1, 6'd5, 2'd1);
    cyc("rr.g1", 4'b0100);
    outc("rr.o1", 1, 1, 6'd6, 2'd2);
    cyc("rr.g2", 4'b1000);
    outc("rr.o2", 1, 1, 6'd7, 2'd3);
    cyc("rr.g3", 4'b0010);
    outc("rr.o3", 1, 1, 6'd5, 2'd1);
    idle_all();
    cyc("rr.idle", 4'b0000);
    chk("rr.v0", 64'(valid_out), 64'h0);

    // starvation: MUL overrides EX after MAX_WAIT blocked cycles
    valid_in_ex = 1; rd_addr_ex = 6'd1;
    valid_in_mul = 1; rd_addr_mul = 6'd2;
    for (int i = 0; i < 4; i++) cyc($sformatf("st.ex%0d", i), 4'b0001);
    cyc("st.mul", 4'b0010);
    outc("st.omul", 1, 1, 6'd2, 2'd1);
    valid_in_mul = 0;
    cyc("st.ex5", 4'b0001);
    outc("st.oex", 1, 1, 6'd1, 2'd0);

    // backpressure holds the output stage
    rd_addr_ex = 6'd9; rd_data_ex = 32'hDEADBEEF;
    cyc("bp.load", 4'b0001);
    rd_addr_ex = 6'd10; rd_data_ex = 32'h11111111;
    ready_in = 0;
    for (int i = 0; i < 3; i++) begin
      cyc($sformatf("bp.hold%0d", i), 4'b0000);
      outc($sformatf("bp.o%0d", i), 1, 1, 6'd9, 2'd0);
      chk($sformatf("bp.d%0d", i), 64'(rd_data_to_WB), 64'hDEADBEEF);
    end
    ready_in = 1;
    cyc("bp.rel", 4'b0001);
    outc("bp.onext", 1, 1, 6'd10, 2'd0);
    chk("bp.dnext", 64'(rd_data_to_WB), 64'h11111111);
    idle_all();
    cyc("bp.idle", 4'b0000);
    chk("bp.nodup", 64'(valid_out), 64'h0);

    // wena=0 result from DIV, then pointer sits at FPU
    valid_in_div = 1; rd_wena_div = 0; rd_addr_div = 6'd12;
    cyc("we0.g", 4'b0100);
    outc("we0.o", 1, 0, 6'd12, 2'd2);
    valid_in_div = 0; rd_wena_div = 1;
    valid_in_mul = 1; valid_in_fpu = 1; rd_addr_fpu = 6'd7;
    cyc("we0.ptr", 4'b1000);
    outc("we0.ofpu", 1, 1, 6'd7, 2'd3);

    // DIV grant moves pointer to FPU, then FPU waits 3 cycles under stall
    valid_in_mul = 0; valid_in_fpu = 0;
    valid_in_div = 1; rd_addr_div = 6'd13;
    cyc("mr.div", 4'b0100);
    valid_in_div = 0;
    valid_in_fpu = 1; rd_addr_fpu = 6'd14;
    ready_in = 0;
    for (int i = 0; i < 3; i++) cyc($sformatf("mr.blk%0d", i), 4'b0000);
    outc("mr.hold", 1, 1, 6'd13, 2'd2);
    #1;
    reset = 0;
    #1;
    outc("mr.async", 0, 0, 6'd0, 2'd0);
    chk("mr.rdy", 64'(rdy), 64'h0);
    @(negedge clk);
    reset = 1;
    ready_in = 1;
    valid_in_mul = 1; rd_addr_mul = 6'd20;
    valid_in_fpu = 1; rd_addr_fpu = 6'd21;
    cyc("mr.ptr", 4'b0010);
    outc("mr.omul", 1, 1, 6'd20, 2'd1);
    valid_in_mul = 0;
    valid_in_ex = 1; rd_addr_ex = 6'd22;
    for (int i = 0; i < 3; i++) cyc($sformatf("mr.ex%0d", i), 4'b0001);
    cyc("mr.fpu", 4'b1000);
    outc("mr.ofpu", 1, 1, 6'd21, 2'd3);
    idle_all();
    cyc("mr.idle", 4'b0000);
    chk("mr.v0", 64'(valid_out), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single register-file write port among four result producers: the in-order EX/MEM pipe, the MUL unit, the DIV unit and the FPU.
- Arbitrates using EX-priority with starvation protection for the long-latency units, and round-robin among those units.
- Registers the granted result into one output stage that drives rd_wena_to_WB / rd_addr_to_WB / rd_data_to_WB toward the register file and forwarding logic.
- Gives one-cycle latency and one writeback per cycle.

Parameters:
- DATA_W, 32, result data width.
- ADDR_W, 6, destination register address width (bit 5 = FP register file).
- MAX_WAIT, 4, cycles a MUL/DIV/FPU request may be blocked before it overrides EX priority (≥1).
- WAIT_W, 3, width of the per-unit wait counters (must hold MAX_WAIT).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- valid_in_ex / valid_in_mul / valid_in_div / valid_in_fpu  in  1 each  requester has a result.
- ready_out_ex / ready_out_mul / ready_out_div / ready_out_fpu  out  1 each  result accepted this cycle.
- rd_wena_ex/_mul/_div/_fpu  in  1 each  result writes a register.
- rd_addr_ex/_mul/_div/_fpu  in  ADDR_W each  destination register.
- rd_data_ex/_mul/_div/_fpu  in  DATA_W each  result data.
- valid_out  out  1  output stage holds a result.
- ready_in  in  1  downstream accepts the output stage.
- rd_wena_to_WB  out  1  register-file write enable, equal to valid_out AND stored wena.
- rd_addr_to_WB  out  ADDR_W  register-file write address.
- rd_data_to_WB  out  DATA_W  register-file write data.
- src_WB  out  2  source of the output result: 0=EX, 1=MUL, 2=DIV, 3=FPU.

Behaviour:
- Reset (reset=0, asynchronous):
  - Clears valid_out, rd_wena_to_WB, rd_addr_to_WB, rd_data_to_WB and src_WB to 0.
  - Clears all wait counters to 0 and sets the round-robin pointer to MUL.
  - All ready_out_* are 0 while reset is asserted.
  - Reset during an operation drops the held and pending results; requesters are flushed by their own reset.
- Load condition: load = !valid_out || ready_in. When load is 0, all ready_out_* are 0 and the output stage holds.
- Grant (combinational, evaluated only when load = 1):
  1. Starved set S = {u in MUL, DIV, FPU : valid_in_u && wait_u >= MAX_WAIT}. If S is non-empty, grant the first member of S in round-robin order starting at the pointer.
  2. Else, if valid_in_ex, grant EX.
  3. Else, grant the first valid MUL/DIV/FPU in round-robin order starting at the pointer.
  4. Else, no grant.
- ready_out_k = grant_k && load. At most one ready_out is high per cycle.
- Output stage update on a clock edge with load = 1:
  - If a grant exists: valid_out <= 1, and the granted wena/addr/data/src are captured.
  - If no grant exists: valid_out <= 0.
- Results with wena=0 still use a slot; rd_wena_to_WB is 0 for them.
- Latency: a result handshaken in cycle n appears on rd_*_to_WB in cycle n+1.
- Throughput: 1 result/cycle while ready_in = 1.
- Round-robin pointer: after granting a long-latency unit u, the pointer moves to the unit after u (MUL→DIV→FPU→MUL). An EX grant leaves the pointer unchanged.
- Wait counters (MUL/DIV/FPU only), updated each cycle:
  - Cleared to 0 if valid_in_u=0 or ready_out_u=1.
  - Otherwise incremented, saturating at MAX_WAIT.
  - Counters also increment in cycles where load=0.
- Requester contract: once valid_in_u is high, it stays high with stable wena/addr/data until ready_out_u. The arbiter never de-grants a handshaken result.
- No same-cycle combinational path from ready_in to valid_out. The path ready_in → ready_out_* is permitted.
- Address 0 with wena=1 is passed through unchanged; x0 suppression is done by the register file.

Test Plan:
- Reset: hold reset=0 with all valid_in=1 → all ready_out=0 and valid_out=0. Release reset → next cycle EX is granted; src_WB=0 one cycle later.
- Round-robin: MUL, DIV and FPU held valid with distinct addrs 5/6/7, EX idle, ready_in=1 → grants MUL, DIV, FPU, MUL in consecutive cycles; rd_addr_to_WB shows 5, 6, 7, 5, each one cycle after its grant.
- Starvation: EX valid every cycle and MUL valid from cycle 0, MAX_WAIT=4 → MUL blocked in cycles 0–3 and granted in cycle 4; EX granted again in cycle 5.
- Backpressure: ready_in=0 for 3 cycles with the output holding {addr=9, data=0xDEADBEEF} → outputs stable and all ready_out=0. Raise ready_in → the next result loads the same cycle; no gap and no duplicate.
- wena=0 passthrough: DIV result with wena=0, addr=12 → valid_out=1, rd_wena_to_WB=0, src_WB=2; the DIV pointer still advances to FPU.
- Reset mid-stream: assert reset while valid_out=1 and FPU wait=3 → valid_out=0 immediately (asynchronous), wait counter cleared, pointer back to MUL.
